// File: rtl/vita49_pkg.sv
// Shared VITA-49 timestamp widths, trigger FSM encoding and ctrl register bit positions.
package vita49_pkg;

    localparam int unsigned TsiW  = 32;
    localparam int unsigned TsfW  = 64;
    localparam int unsigned TsW   = TsiW + TsfW;
    localparam int unsigned CtrlW = 32;

    localparam int unsigned CtrlArm    = 0;
    localparam int unsigned CtrlCancel = 1;
    localparam int unsigned CtrlImm    = 2;
    localparam int unsigned CtrlCont   = 3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StArmed  = 2'd1,
        StActive = 2'd2,
        StLate   = 2'd3
    } trig_state_e;

endpackage

// File: rtl/vita49_ts_cmp.sv
// Registered unsigned {tsi,tsf} >= target comparator; one cycle of latency.
module vita49_ts_cmp
    import vita49_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [TsW-1:0] ts_i,
    input  logic [TsW-1:0] target_i,
    output logic           ge_o
);

    logic ge_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ge_q <= 1'b0;
        end else begin
            ge_q <= (ts_i >= target_i);
        end
    end

    assign ge_o = ge_q;

endmodule

// File: rtl/vita49_tsf_trigger.sv
// Timestamp-triggered burst gate: arms on a ctrl edge, opens the sample gate when the
// channel timestamp reaches the latched target, and closes it after burst_len samples.
module vita49_tsf_trigger
    import vita49_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter bit          LATE_CHECK = 1'b1
) (
    input  logic             samp_clk,
    input  logic             ARESETN,
    input  logic [TsiW-1:0]  tsi,
    input  logic [TsfW-1:0]  tsf,
    input  logic [CtrlW-1:0] ctrl,
    input  logic [TsiW-1:0]  trig_tsi,
    input  logic [TsfW-1:0]  trig_tsf,
    input  logic [CNT_W-1:0] burst_len,
    output logic             gate,
    output logic             busy,
    output logic             done,
    output logic             late,
    output logic [1:0]       state
);

    trig_state_e state_q, state_d;

    logic             primed_q;
    logic             arm_lvl_q, cancel_lvl_q;
    logic             arm_q, cancel_q, imm_q, cont_req_q;
    logic [TsW-1:0]   tgt_q, tgt_d;
    logic [CNT_W-1:0] blen_q, blen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cont_q, cont_d;
    logic             late_q, late_d;
    logic             first_q, first_d;
    logic             done_q, done_d;
    logic             ts_ge;
    logic             unused_ctrl;

    assign unused_ctrl = ^ctrl[CtrlW-1:CtrlCont+1];

    // primed_q masks the first cycle after reset so a level already high is not an edge
    always_ff @(posedge samp_clk or negedge ARESETN) begin
        if (!ARESETN) begin
            primed_q     <= 1'b0;
            arm_lvl_q    <= 1'b0;
            cancel_lvl_q <= 1'b0;
            arm_q        <= 1'b0;
            cancel_q     <= 1'b0;
            imm_q        <= 1'b0;
            cont_req_q   <= 1'b0;
        end else begin
            primed_q     <= 1'b1;
            arm_lvl_q    <= ctrl[CtrlArm];
            cancel_lvl_q <= ctrl[CtrlCancel];
            arm_q        <= primed_q & ctrl[CtrlArm] & ~arm_lvl_q;
            cancel_q     <= primed_q & ctrl[CtrlCancel] & ~cancel_lvl_q;
            imm_q        <= ctrl[CtrlImm];
            cont_req_q   <= ctrl[CtrlCont];
        end
    end

    // Fed with the next-state target so the first ARMED cycle already compares the new target
    vita49_ts_cmp u_ts_cmp (
        .clk_i    (samp_clk),
        .rst_ni   (ARESETN),
        .ts_i     ({tsi, tsf}),
        .target_i (tgt_d),
        .ge_o     (ts_ge)
    );

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        blen_d  = blen_q;
        cnt_d   = cnt_q;
        cont_d  = cont_q;
        late_d  = late_q;
        first_d = 1'b0;
        done_d  = 1'b0;
        if (cancel_q) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (arm_q) begin
                        tgt_d  = {trig_tsi, trig_tsf};
                        blen_d = burst_len;
                        cont_d = cont_req_q;
                        late_d = 1'b0;
                        if (imm_q) begin
                            state_d = StActive;
                            cnt_d   = burst_len;
                        end else begin
                            state_d = StArmed;
                            first_d = 1'b1;
                        end
                    end
                end
                StArmed: begin
                    if (ts_ge) begin
                        if (LATE_CHECK && first_q) begin
                            state_d = StLate;
                            late_d  = 1'b1;
                        end else begin
                            state_d = StActive;
                            cnt_d   = blen_q;
                        end
                    end
                end
                StActive: begin
                    if (!cont_q) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                // LATE is left only through cancel
                default: ;
            endcase
        end
    end

    always_ff @(posedge samp_clk or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= StIdle;
            tgt_q   <= '0;
            blen_q  <= '0;
            cnt_q   <= '0;
            cont_q  <= 1'b0;
            late_q  <= 1'b0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            blen_q  <= blen_d;
            cnt_q   <= cnt_d;
            cont_q  <= cont_d;
            late_q  <= late_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

    // A zero-length burst spends its single ACTIVE cycle with the gate closed
    assign gate  = (state_q == StActive) && (cont_q || (cnt_q != '0));
    assign busy  = (state_q == StArmed) || (state_q == StActive);
    assign done  = done_q;
    assign late  = late_q;
    assign state = state_q;

endmodule

// File: tb/tb_vita49_tsf_trigger.sv
// Randomized bench for vita49_tsf_trigger against a timeline model of each trigger episode.
module tb_vita49_tsf_trigger;
    import vita49_pkg::*;

    localparam int Never = 1 << 30;

    logic        samp_clk  = 1'b0;
    logic        ARESETN   = 1'b0;
    logic [31:0] tsi       = '0;
    logic [63:0] tsf       = '0;
    logic [31:0] ctrl      = '0;
    logic [31:0] trig_tsi  = '0;
    logic [63:0] trig_tsf  = '0;
    logic [31:0] burst_len = '0;
    logic        gate, busy, done, late;
    logic [1:0]  state;

    vita49_tsf_trigger #(
        .CNT_W      (32),
        .LATE_CHECK (1'b1)
    ) dut (
        .samp_clk  (samp_clk),
        .ARESETN   (ARESETN),
        .tsi       (tsi),
        .tsf       (tsf),
        .ctrl      (ctrl),
        .trig_tsi  (trig_tsi),
        .trig_tsf  (trig_tsf),
        .burst_len (burst_len),
        .gate      (gate),
        .busy      (busy),
        .done      (done),
        .late      (late),
        .state     (state)
    );

    always #5 samp_clk = ~samp_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Episode model: arm presented in cycle c_m; gate window, done cycle and states follow
    int c_m = 0, rise_m = Never, kill_m = Never, n_m = 0, alen_m = 1;
    bit cont_m = 1'b0, late_case_m = 1'b0, never_m = 1'b0, late_prev_m = 1'b0, late_m = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge samp_clk);
        #1;
        cyc++;
        tsf = tsf + 64'd1;
    endtask

    function automatic logic [1:0] exp_state(input int k);
        if (k < c_m + 2 || k >= kill_m) return 2'd0;
        if (late_case_m) return (k == c_m + 2) ? 2'd1 : 2'd3;
        if (never_m || k < rise_m) return 2'd1;
        if (cont_m || k < rise_m + alen_m) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit exp_gate(input int k);
        if (late_case_m || never_m || k < rise_m || k >= kill_m) return 1'b0;
        if (cont_m) return 1'b1;
        return k < rise_m + n_m;
    endfunction

    function automatic bit exp_done(input int k);
        if (late_case_m || never_m || cont_m) return 1'b0;
        return (k == rise_m + alen_m) && (kill_m > rise_m + alen_m);
    endfunction

    function automatic bit exp_late(input int k);
        if (k < c_m + 2) return late_prev_m;
        return late_case_m && (k >= c_m + 3);
    endfunction

    task automatic check_outputs();
        logic [1:0] st;
        st = exp_state(cyc);
        check_eq("state", state, st);
        check_eq("busy", busy, st == 2'd1 || st == 2'd2);
        check_eq("gate", gate, exp_gate(cyc));
        check_eq("done", done, exp_done(cyc));
        check_eq("late", late, exp_late(cyc));
    endtask

    task automatic run_case(input bit imm, input bit cont, input logic [31:0] ttsi,
                            input logic [63:0] ttsf, input int n, input logic [63:0] x,
                            input int hold, input bit both, input bit abort);
        logic [31:0] junk;
        logic [31:0] arm_ctrl;
        bit          rearm_ok;
        junk        = $urandom();
        late_prev_m = late_m;
        c_m         = cyc;
        kill_m      = Never;
        cont_m      = cont;
        n_m         = n;
        alen_m      = (n == 0) ? 1 : n;
        late_case_m = 1'b0;
        never_m     = 1'b0;
        rise_m      = Never;
        // Timestamp seen by the first compare is the one presented the cycle after arm
        if (imm) rise_m = c_m + 2;
        else if ({tsi, x + 64'd1} >= {ttsi, ttsf}) late_case_m = 1'b1;
        else if (ttsi == tsi) rise_m = c_m + int'(ttsf - x) + 2;
        else never_m = 1'b1;
        rearm_ok  = !cont && (late_case_m || never_m || (rise_m + alen_m > c_m + 4));
        arm_ctrl  = {junk[31:4], cont, imm, 2'b01};
        tsf       = x;
        trig_tsi  = ttsi;
        trig_tsf  = ttsf;
        burst_len = n;
        ctrl      = arm_ctrl;
        for (int i = 1; i <= hold; i++) begin
            step();
            check_outputs();
            if (!cont) ctrl = (i == 3 && rearm_ok) ? 32'h1 : 32'h0;
            if (i >= 2) begin
                trig_tsi  = $urandom();
                trig_tsf  = {$urandom(), $urandom()};
                burst_len = $urandom_range(0, 40);
            end
        end
        if (abort) return;
        if (exp_state(cyc) != 2'd0) begin
            kill_m = cyc + 2;
            ctrl   = cont ? (arm_ctrl | 32'h2) : (both ? 32'h3 : 32'h2);
            for (int i = 0; i < 3; i++) begin
                step();
                check_outputs();
            end
            ctrl = 32'h0;
        end
        step();
        check_outputs();
        late_m = late_case_m;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          r_imm, r_cont, r_both;
        int          r_off, r_n;
        logic [31:0] r_ttsi;
        logic [63:0] r_x;

        // Reset with arm level already high; release must not produce an arm
        ctrl = 32'h1;
        step();
        step();
        check_eq("rst_state", state, 2'd0);
        check_eq("rst_gate", gate, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_late", late, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        ARESETN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("release_state", state, 2'd0);
            check_eq("release_gate", gate, 1'b0);
        end
        ctrl = 32'h0;
        step();

        tsi = 32'h0;
        run_case(1'b1, 1'b0, 32'h0, 64'h0, 4, 64'h10, 12, 1'b0, 1'b0);
        run_case(1'b0, 1'b0, 32'h0, 64'h200, 16, 64'h100, 280, 1'b0, 1'b0);
        run_case(1'b0, 1'b0, 32'h0, 64'h100, 5, 64'h180, 20, 1'b0, 1'b0);
        run_case(1'b1, 1'b1, 32'h0, 64'h0, 7, 64'h20, 100, 1'b0, 1'b0);
        run_case(1'b0, 1'b0, 32'h0, 64'h1200, 8, 64'h1000, 10, 1'b1, 1'b0);
        run_case(1'b1, 1'b0, 32'h0, 64'h0, 0, 64'h30, 8, 1'b0, 1'b0);

        for (int r = 0; r < 16; r++) begin
            tsi    = $urandom_range(1, 1000);
            r_imm  = ($urandom_range(0, 2) == 0);
            r_cont = ($urandom_range(0, 4) == 0);
            r_both = ($urandom_range(0, 1) == 1);
            r_n    = $urandom_range(0, 20);
            r_x    = 64'($urandom_range(64, 60000));
            r_off  = $urandom_range(0, 46) - 6;
            case ($urandom_range(0, 5))
                0:       r_ttsi = tsi - 32'd1;
                1:       r_ttsi = tsi + 32'd1;
                default: r_ttsi = tsi;
            endcase
            run_case(r_imm, r_cont, r_ttsi, r_x + 64'(r_off), r_n, r_x, 70, r_both, 1'b0);
        end

        // Reset with gate open after 8 of 16 samples
        tsi = 32'h0;
        run_case(1'b1, 1'b0, 32'h0, 64'h0, 16, 64'h40, 9, 1'b0, 1'b1);
        ctrl = 32'h1;
        #2;
        ARESETN = 1'b0;
        #1;
        check_eq("midrst_gate", gate, 1'b0);
        check_eq("midrst_state", state, 2'd0);
        check_eq("midrst_done", done, 1'b0);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_late", late, 1'b0);
        step();
        step();
        ARESETN = 1'b1;
        late_m  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("midrst_arm_state", state, 2'd0);
            check_eq("midrst_arm_gate", gate, 1'b0);
            check_eq("midrst_arm_done", done, 1'b0);
        end
        ctrl = 32'h0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
